// File: rtl/chess_link_ctrl.sv
// Packet-link controller between the chess game logic and the UART core:
// queued TX of setup/move/result packets, RX fetch/decode into one-cycle events, turn tracking.
module chess_link_ctrl #(
    parameter int PKT_W     = 16,
    parameter int TXQ_DEPTH = 4,
    parameter int MIRROR    = 1,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             setup_req,
    input  logic             setup_player,
    input  logic [1:0]       setup_mode,
    input  logic             move_req,
    input  logic [11:0]      move_coords,
    input  logic             result_req,
    input  logic             result_won,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [PKT_W-1:0] tx_data,
    input  logic             rx_pending,
    output logic             rx_req,
    input  logic [PKT_W-1:0] rx_data,
    input  logic             rx_parity_err,
    output logic             rx_move_valid,
    output logic [11:0]      rx_move,
    output logic             rx_setup_valid,
    output logic [1:0]       rx_mode,
    output logic             rx_result_valid,
    output logic             rx_remote_won,
    output logic             local_player,
    output logic             my_turn,
    output logic             tx_overflow,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int AW = $clog2(TXQ_DEPTH);
    localparam logic [AW:0] FULL_CNT = TXQ_DEPTH[AW:0];

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_REQ,
        RX_WAIT,
        RX_DECODE
    } rx_state_t;

    // ---------------- TX queue ----------------
    logic [PKT_W-1:0] fifo_mem [TXQ_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             gap_reg;
    logic             overflow_reg;
    logic             fifo_full, any_req, multi_req, push_en, pop_en;
    logic [15:0]      push_hdr;
    logic [PKT_W-1:0] push_data;

    always_comb begin
        push_hdr = '0;
        if (result_req)
            push_hdr = {2'b11, result_won, 13'b0};
        else if (setup_req)
            push_hdr = {2'b10, setup_player, setup_mode, 11'b0};
        else if (move_req)
            push_hdr = {2'b00, move_coords, 2'b00};
        push_data = '0;
        push_data[PKT_W-1 -: 16] = push_hdr;
    end

    assign any_req   = result_req || setup_req || move_req;
    assign multi_req = (result_req && setup_req) || (result_req && move_req) || (setup_req && move_req);
    assign fifo_full = (count_reg == FULL_CNT);
    assign push_en   = any_req && !fifo_full;
    // gap_reg forces an idle cycle between strobes
    assign tx_valid  = (count_reg != '0) && tx_ready && !gap_reg;
    assign pop_en    = tx_valid;
    assign tx_data   = tx_valid ? fifo_mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (push_en)
            fifo_mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            gap_reg      <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_en)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_en)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            gap_reg      <= pop_en;
            overflow_reg <= (any_req && fifo_full) || multi_req;
        end
    end

    assign tx_overflow = overflow_reg;

    // ---------------- RX fetch FSM ----------------
    rx_state_t state_reg, state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= RX_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        rx_req     = 1'b0;
        unique case (state_reg)
            RX_IDLE:   if (rx_pending) state_next = RX_REQ;
            RX_REQ: begin
                rx_req     = 1'b1;
                state_next = RX_WAIT;
            end
            RX_WAIT:   state_next = RX_DECODE;
            RX_DECODE: state_next = RX_IDLE;
            default:   state_next = RX_IDLE;
        endcase
    end

    // Data is captured on the edge into DECODE so the registered events are visible during DECODE.
    logic        decode_en, rx_bad, dec_move, dec_setup, dec_result;
    logic [1:0]  rx_type, rx_mode_f;
    logic        rx_flag;
    logic [11:0] rx_coords_raw, rx_coords_dec;
    logic        unused_rx_bits;

    assign rx_type       = rx_data[PKT_W-1 -: 2];
    assign rx_flag       = rx_data[PKT_W-3];
    assign rx_mode_f     = rx_data[PKT_W-4 -: 2];
    assign rx_coords_raw = rx_data[PKT_W-3 -: 12];
    // low packet bits carry nothing on receive
    assign unused_rx_bits = ^rx_data[PKT_W-15:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_coord
            assign rx_coords_dec[gi*3 +: 3] = (MIRROR != 0) ? (3'd7 - rx_coords_raw[gi*3 +: 3])
                                                            : rx_coords_raw[gi*3 +: 3];
        end
    endgenerate

    assign decode_en  = (state_reg == RX_WAIT);
    assign rx_bad     = rx_parity_err || (rx_type == 2'b01);
    assign dec_move   = decode_en && !rx_bad && (rx_type == 2'b00);
    assign dec_setup  = decode_en && !rx_bad && (rx_type == 2'b10);
    assign dec_result = decode_en && !rx_bad && (rx_type == 2'b11);

    // ---------------- turn / colour tracking ----------------
    logic my_turn_reg, my_turn_next, local_player_reg, local_player_next;

    always_comb begin
        my_turn_next      = my_turn_reg;
        local_player_next = local_player_reg;
        if (dec_move)
            my_turn_next = 1'b1;
        if (dec_setup) begin
            local_player_next = ~rx_flag;
            my_turn_next      = rx_flag;
        end
        // local requests are applied last so they override a same-cycle decode
        if (move_req)
            my_turn_next = 1'b0;
        if (setup_req) begin
            local_player_next = setup_player;
            my_turn_next      = ~setup_player;
        end
    end

    logic             move_valid_reg, setup_valid_reg, result_valid_reg, remote_won_reg;
    logic [11:0]      rx_move_reg;
    logic [1:0]       rx_mode_reg;
    logic [ERR_W-1:0] err_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            my_turn_reg      <= 1'b0;
            local_player_reg <= 1'b0;
            move_valid_reg   <= 1'b0;
            setup_valid_reg  <= 1'b0;
            result_valid_reg <= 1'b0;
            remote_won_reg   <= 1'b0;
            rx_move_reg      <= '0;
            rx_mode_reg      <= '0;
            err_cnt_reg      <= '0;
        end else begin
            my_turn_reg      <= my_turn_next;
            local_player_reg <= local_player_next;
            move_valid_reg   <= dec_move;
            setup_valid_reg  <= dec_setup;
            result_valid_reg <= dec_result;
            if (dec_move)
                rx_move_reg <= rx_coords_dec;
            if (dec_setup)
                rx_mode_reg <= rx_mode_f;
            if (dec_result)
                remote_won_reg <= rx_flag;
            if (decode_en && rx_bad && !(&err_cnt_reg))
                err_cnt_reg <= err_cnt_reg + ERR_W'(1);
        end
    end

    assign my_turn         = my_turn_reg;
    assign local_player    = local_player_reg;
    assign rx_move_valid   = move_valid_reg;
    assign rx_setup_valid  = setup_valid_reg;
    assign rx_result_valid = result_valid_reg;
    assign rx_move         = rx_move_reg;
    assign rx_mode         = rx_mode_reg;
    assign rx_remote_won   = remote_won_reg;
    assign err_cnt         = err_cnt_reg;

endmodule

// File: tb/tb_chess_link_ctrl.sv
// Randomised + directed bench for chess_link_ctrl against a transaction-level model
// (packet queue, timestamped RX fetches, turn/colour variables).
module tb_chess_link_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        setup_req = 0, setup_player = 0, move_req = 0, result_req = 0, result_won = 0;
    logic [1:0]  setup_mode = 0;
    logic [11:0] move_coords = 0;
    logic        tx_ready = 0, rx_pending = 0, rx_parity_err = 0;
    logic [15:0] rx_data = 0;
    logic        tx_valid, rx_req, rx_move_valid, rx_setup_valid, rx_result_valid;
    logic        rx_remote_won, local_player, my_turn, tx_overflow;
    logic [15:0] tx_data;
    logic [11:0] rx_move;
    logic [1:0]  rx_mode;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    chess_link_ctrl #(.PKT_W(16), .TXQ_DEPTH(DEPTH), .MIRROR(1), .ERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .setup_req(setup_req), .setup_player(setup_player), .setup_mode(setup_mode),
        .move_req(move_req), .move_coords(move_coords),
        .result_req(result_req), .result_won(result_won),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .rx_pending(rx_pending), .rx_req(rx_req), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .rx_move_valid(rx_move_valid), .rx_move(rx_move),
        .rx_setup_valid(rx_setup_valid), .rx_mode(rx_mode),
        .rx_result_valid(rx_result_valid), .rx_remote_won(rx_remote_won),
        .local_player(local_player), .my_turn(my_turn),
        .tx_overflow(tx_overflow), .err_cnt(err_cnt)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] q[$];
    logic [15:0] cap[$];
    bit          gap, m_turn, m_player, m_ovf, m_mv_v, m_su_v, m_rs_v, m_won;
    logic [11:0] m_move;
    logic [1:0]  m_mode;
    int          m_err, cyc, rx_start, ovf_seen, evt_seen;

    function automatic logic [15:0] mk_move(input logic [11:0] c);
        return {2'b00, c, 2'b00};
    endfunction
    function automatic logic [15:0] mk_setup(input logic p, input logic [1:0] m);
        return {2'b10, p, m, 11'b0};
    endfunction
    function automatic logic [15:0] mk_result(input logic w);
        return {2'b11, w, 13'b0};
    endfunction
    function automatic logic [11:0] mirror(input logic [11:0] c);
        int r = 0;
        for (int i = 0; i < 4; i++)
            r += (7 - ((int'(c) >> (3 * i)) & 7)) << (3 * i);
        return 12'(r);
    endfunction

    task automatic model_reset();
        q.delete();
        gap = 0; m_turn = 0; m_player = 0; m_ovf = 0;
        m_mv_v = 0; m_su_v = 0; m_rs_v = 0; m_won = 0;
        m_move = 0; m_mode = 0; m_err = 0; rx_start = -100;
    endtask

    // One clock cycle: inputs are already driven (posedge+1).
    task automatic tick();
        bit ev, er, full;
        logic [15:0] ed, hdr, pkt;
        int n;
        #1;
        ev = (q.size() != 0) && tx_ready && !gap;
        ed = ev ? q[0] : 16'h0;
        er = (cyc == rx_start + 1);
        check("tx_valid", tx_valid, ev);
        check("tx_data", tx_data, ed);
        check("rx_req", rx_req, er);
        if (tx_valid) begin
            cap.push_back(tx_data);
            $display("cycle %0d: tx packet %04h", cyc, tx_data);
        end
        m_mv_v = 0; m_su_v = 0; m_rs_v = 0;
        if (cyc == rx_start + 2) begin
            pkt = rx_data;
            if (rx_parity_err || pkt[15:14] == 2'b01) begin
                if (m_err < 255) m_err++;
            end else if (pkt[15:14] == 2'b00) begin
                m_mv_v = 1; m_move = mirror(pkt[13:2]); m_turn = 1;
            end else if (pkt[15:14] == 2'b10) begin
                m_su_v = 1; m_player = ~pkt[13]; m_turn = pkt[13]; m_mode = pkt[12:11];
            end else begin
                m_rs_v = 1; m_won = pkt[13];
            end
        end
        if (cyc >= rx_start + 4 && rx_pending) rx_start = cyc;
        if (move_req) m_turn = 0;
        if (setup_req) begin m_player = setup_player; m_turn = ~setup_player; end
        n = int'(result_req) + int'(setup_req) + int'(move_req);
        full = (q.size() == DEPTH);
        hdr = result_req ? mk_result(result_won) :
              setup_req  ? mk_setup(setup_player, setup_mode) : mk_move(move_coords);
        if (ev) void'(q.pop_front());
        if (n > 0 && !full) q.push_back(hdr);
        m_ovf = (n > 0 && full) || n > 1;
        gap = ev;
        @(posedge clk);
        #1;
        cyc++;
        check("my_turn", my_turn, m_turn);
        check("local_player", local_player, m_player);
        check("err_cnt", err_cnt, m_err);
        check("tx_overflow", tx_overflow, m_ovf);
        check("rx_move_valid", rx_move_valid, m_mv_v);
        check("rx_setup_valid", rx_setup_valid, m_su_v);
        check("rx_result_valid", rx_result_valid, m_rs_v);
        check("rx_mode", rx_mode, m_mode);
        check("rx_remote_won", rx_remote_won, m_won);
        if (m_mv_v) check("rx_move", rx_move, m_move);
        if (er) rx_pending = 0;
        if (tx_overflow) ovf_seen++;
        if (rx_move_valid || rx_setup_valid || rx_result_valid) begin
            evt_seen++;
            $display("cycle %0d: rx event move=%0b setup=%0b result=%0b coords=%03h", cyc,
                     rx_move_valid, rx_setup_valid, rx_result_valid, rx_move);
        end
    endtask

    task automatic clear_reqs();
        setup_req = 0; move_req = 0; result_req = 0;
    endtask

    task automatic idle(input int n);
        clear_reqs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rx_offer(input logic [15:0] pkt, input logic par);
        rx_data = pkt; rx_parity_err = par; rx_pending = 1;
    endtask

    function automatic logic [15:0] rand_pkt();
        logic [31:0] r = $urandom;
        case (r[31:30])
            2'd0:    return {2'b00, r[11:0], 2'b00};
            2'd1:    return {2'b10, r[2:0], 11'b0};
            2'd2:    return {2'b11, r[0], 13'b0};
            default: return {2'b01, r[13:0]};
        endcase
    endfunction

    logic [11:0] mv_c [5];
    int base, start, seen;

    initial begin
        model_reset();
        cyc = 0; ovf_seen = 0; evt_seen = 0;
        tx_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rx_req", rx_req, 0);
        check("rst_my_turn", my_turn, 0);
        check("rst_local_player", local_player, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_tx_overflow", tx_overflow, 0);
        check("rst_events", {rx_move_valid, rx_setup_valid, rx_result_valid}, 0);
        check("rst_rx_move", rx_move, 0);
        check("rst_rx_mode", rx_mode, 0);
        check("rst_remote_won", rx_remote_won, 0);
        reset_n = 1;
        @(posedge clk);
        #1;

        // local setup player=1 mode=2
        cap.delete();
        setup_req = 1; setup_player = 1; setup_mode = 2;
        tick();
        check("setup_local_player", local_player, 1);
        check("setup_my_turn", my_turn, 0);
        idle(1);
        check("setup_strobe_count", cap.size(), 1);
        if (cap.size() > 0) check("setup_pkt", cap[0], 16'hB000);

        // local move 1A3
        idle(2);
        cap.delete();
        move_req = 1; move_coords = 12'h1A3;
        tick();
        check("move_my_turn", my_turn, 0);
        idle(1);
        check("move_strobe_count", cap.size(), 1);
        if (cap.size() > 0) check("move_pkt", cap[0], 16'h068C);

        // five moves into a stalled queue of depth 4
        idle(2);
        tx_ready = 0;
        base = ovf_seen;
        for (int i = 0; i < 5; i++) begin
            mv_c[i] = 12'($urandom);
            move_req = 1; move_coords = mv_c[i];
            tick();
        end
        idle(1);
        check("five_moves_overflow", ovf_seen - base, 1);
        cap.delete();
        tx_ready = 1;
        idle(10);
        check("drain_count", cap.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < cap.size()) check("drain_order", cap[i], mk_move(mv_c[i]));

        // RX move 0004 with mirroring, latency N+3
        idle(4);
        rx_offer(16'h0004, 0);
        start = cyc; seen = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rx_move_valid && seen < 0) begin
                seen = cyc;
                check("rx_move_mirror", rx_move, 12'hFFE);
            end
        end
        check("rx_move_latency", seen - start, 3);
        check("rx_move_turn", my_turn, 1);

        // parity error and illegal type: no event, two errors
        base = evt_seen;
        rx_offer(mk_move(12'h123), 1);
        idle(4);
        rx_offer(16'h4000, 0);
        idle(4);
        check("err_no_event", evt_seen - base, 0);
        check("err_cnt_two", err_cnt, 2);
        for (int i = 0; i < 260; i++) begin
            rx_offer(16'h4000 | 16'($urandom_range(255)), 0);
            idle(4);
        end
        check("err_cnt_sat", err_cnt, 8'hFF);
        rx_offer(mk_setup(0, 1), 1);
        idle(4);
        check("err_cnt_hold", err_cnt, 8'hFF);

        // three simultaneous requests
        idle(3);
        base = ovf_seen;
        cap.delete();
        result_req = 1; result_won = 1; setup_req = 1; setup_player = 0; setup_mode = 1;
        move_req = 1; move_coords = 12'h555;
        tick();
        idle(3);
        check("triple_overflow", ovf_seen - base, 1);
        check("triple_count", cap.size(), 1);
        if (cap.size() > 0) check("triple_pkt", cap[0], 16'hE000);

        // reset mid-operation discards queue and in-flight fetch
        tx_ready = 0;
        for (int i = 0; i < 3; i++) begin
            move_req = 1; move_coords = 12'($urandom);
            tick();
        end
        clear_reqs();
        rx_offer(mk_move(12'h0AB), 0);
        tick();
        reset_n = 0;
        rx_pending = 0;
        tx_ready = 1;
        #1;
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        model_reset();
        base = evt_seen;
        cap.delete();
        @(posedge clk);
        #1;
        cyc++;
        idle(6);
        check("midrst_no_drain", cap.size(), 0);
        check("midrst_no_event", evt_seen - base, 0);

        // randomised traffic
        for (int i = 0; i < 1500; i++) begin
            result_req = ($urandom_range(7) == 0);
            setup_req  = ($urandom_range(7) == 0);
            move_req   = ($urandom_range(3) == 0);
            result_won = 1'($urandom);
            setup_player = 1'($urandom);
            setup_mode = 2'($urandom);
            move_coords = 12'($urandom);
            tx_ready = ($urandom_range(9) < 7);
            if (!rx_pending && cyc >= rx_start + 4 && $urandom_range(2) == 0)
                rx_offer(rand_pkt(), $urandom_range(7) == 0);
            tick();
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
